// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-side bundle of the program counter unit.
// Carries the pipeline control inputs (stall, instruction-memory ready,
// EX-stage redirect, trap) and the fetch address outputs (pc, pc+step,
// valid, misalignment pulse).
//   slave  modport : used by pc_unit (controls in, fetch address out)
//   master modport : used by whoever drives the controls (pipeline / bench)
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            if_ready_i;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_target_i;
    logic            trap_valid_i;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus_o;
    logic            pc_valid_o;
    logic            misalign_o;

    modport slave (
        input  stall_i,
        input  if_ready_i,
        input  redirect_valid_i,
        input  redirect_target_i,
        input  trap_valid_i,
        output pc_o,
        output pc_plus_o,
        output pc_valid_o,
        output misalign_o
    );

    modport master (
        output stall_i,
        output if_ready_i,
        output redirect_valid_i,
        output redirect_target_i,
        output trap_valid_i,
        input  pc_o,
        input  pc_plus_o,
        input  pc_valid_o,
        input  misalign_o
    );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter / fetch address generator.
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   bus   - pc_unit_if.slave: stall_i, if_ready_i, redirect_valid_i,
//           redirect_target_i, trap_valid_i in; pc_o, pc_plus_o,
//           pc_valid_o, misalign_o out
// Behaviour: BOOT (one bubble after reset) -> RUN (sequential fetch by STEP)
// with trap > redirect > stall > advance priority. A trap/redirect that
// arrives while the instruction memory is not ready is parked in a pending
// register (PEND) and applied on the first ready cycle; later events
// overwrite it.
// Build option: define PC_MISALIGN_TRAP_EN to turn misaligned redirects into
// a jump to TRAP_VECTOR with a one-cycle misalign_o pulse. Without it the
// low log2(STEP) target bits are cleared and misalign_o stays 0.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              STEP         = 4,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input logic      clk,
    input logic      rst,
    pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_e;

    // Bits below log2(STEP); any of them set marks a misaligned target.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(STEP - 1);
    localparam logic [XLEN-1:0] STEP_INC = XLEN'(STEP);

    // Returns {misaligned_to_trap, effective_target} for a redirect target.
    function automatic logic [XLEN:0] fix_target(input logic [XLEN-1:0] t);
        logic [XLEN:0] r;
`ifdef PC_MISALIGN_TRAP_EN
        if ((t & LOW_MASK) != {XLEN{1'b0}}) begin
            r = {1'b1, TRAP_VECTOR};
        end else begin
            r = {1'b0, t};
        end
`else
        r = {1'b0, t & ~LOW_MASK};
`endif
        return r;
    endfunction

    state_e          state_r, state_s;
    logic [XLEN-1:0] pc_r, pc_s;
    logic [XLEN-1:0] pend_r, pend_s;
    logic            pend_mis_r, pend_mis_s;
    logic            valid_r;
    logic            mis_r, mis_s;
    logic            event_s;
    logic [XLEN-1:0] evt_target_s;
    logic            evt_mis_s;
    logic [XLEN:0]   fixed_s;

    // Resolve the winning event (trap beats redirect) into one target.
    always_comb begin
        fixed_s      = fix_target(bus.redirect_target_i);
        event_s      = bus.trap_valid_i | bus.redirect_valid_i;
        evt_target_s = {XLEN{1'b0}};
        evt_mis_s    = 1'b0;
        if (bus.trap_valid_i) begin
            evt_target_s = TRAP_VECTOR;
            evt_mis_s    = 1'b0;
        end else begin
            evt_target_s = fixed_s[XLEN-1:0];
            evt_mis_s    = fixed_s[XLEN];
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        pend_s     = pend_r;
        pend_mis_s = pend_mis_r;
        mis_s      = 1'b0;
        case (state_r)
            BOOT: begin
                // An event during the boot bubble is taken directly.
                state_s = RUN;
                if (event_s) begin
                    pc_s  = evt_target_s;
                    mis_s = evt_mis_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            RUN: begin
                if (event_s) begin
                    if (bus.if_ready_i) begin
                        pc_s  = evt_target_s;
                        mis_s = evt_mis_s;
                    end else begin
                        pend_s     = evt_target_s;
                        pend_mis_s = evt_mis_s;
                        state_s    = PEND;
                    end
                end else if (bus.if_ready_i && !bus.stall_i) begin
                    pc_s = pc_r + STEP_INC;
                end else begin
                    pc_s = pc_r;
                end
            end
            PEND: begin
                if (bus.if_ready_i) begin
                    // A same-cycle event is newer than the parked one.
                    state_s = RUN;
                    if (event_s) begin
                        pc_s  = evt_target_s;
                        mis_s = evt_mis_s;
                    end else begin
                        pc_s  = pend_r;
                        mis_s = pend_mis_r;
                    end
                end else if (event_s) begin
                    pend_s     = evt_target_s;
                    pend_mis_s = evt_mis_s;
                end else begin
                    pend_s = pend_r;
                end
            end
            default: begin
                state_s    = BOOT;
                pc_s       = RESET_VECTOR;
                pend_s     = {XLEN{1'b0}};
                pend_mis_s = 1'b0;
            end
        endcase
    end

    // State, PC, pending target and registered output flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= BOOT;
            pc_r       <= RESET_VECTOR;
            pend_r     <= {XLEN{1'b0}};
            pend_mis_r <= 1'b0;
            valid_r    <= 1'b0;
            mis_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            pend_r     <= pend_s;
            pend_mis_r <= pend_mis_s;
            valid_r    <= (state_s == RUN);
            mis_r      <= mis_s;
        end
    end

    assign bus.pc_o       = pc_r;
    assign bus.pc_plus_o  = pc_r + STEP_INC;
    assign bus.pc_valid_o = valid_r;
    assign bus.misalign_o = mis_r;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a behavioural fetch-address model.
module tb_pc_unit;

    localparam logic [31:0] TRAPV = 32'h0000_0100;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_PEND = 2;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    pc_unit_if #(.XLEN(32)) bus ();

    pc_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0000_0000),
        .STEP(4),
        .TRAP_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          mode;
        logic [31:0] pend;
        bit          pend_mis;
        bit          mis;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.pc = 32'h0; r.mode = M_BOOT; r.pend = 32'h0; r.pend_mis = 1'b0; r.mis = 1'b0;
        return r;
    endfunction

    // One clock of the fetch unit described as plain rules.
    function automatic model_t model_step(model_t c, bit stall, bit ready,
                                          bit rv, logic [31:0] rt, bit tv);
        model_t n = c;
        bit ev = tv || rv;
        logic [31:0] tgt;
        bit tm = 1'b0;
        if (tv) tgt = TRAPV;
        else if (rt % 4 != 0) begin
`ifdef PC_MISALIGN_TRAP_EN
            tgt = TRAPV; tm = 1'b1;
`else
            tgt = rt - (rt % 4);
`endif
        end else tgt = rt;
        n.mis = 1'b0;
        if (c.mode == M_BOOT) begin
            n.mode = M_RUN;
            if (ev) begin n.pc = tgt; n.mis = tm; end
        end else if (c.mode == M_RUN) begin
            if (ev && ready) begin n.pc = tgt; n.mis = tm; end
            else if (ev) begin n.pend = tgt; n.pend_mis = tm; n.mode = M_PEND; end
            else if (ready && !stall) n.pc = c.pc + 32'd4;
        end else begin
            if (ready) begin
                n.mode = M_RUN;
                if (ev) begin n.pc = tgt; n.mis = tm; end
                else begin n.pc = c.pend; n.mis = c.pend_mis; end
            end else if (ev) begin
                n.pend = tgt; n.pend_mis = tm;
            end
        end
        return n;
    endfunction

    // Reference model register, reset asynchronously like the design.
    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else m <= model_step(m, bus.stall_i, bus.if_ready_i, bus.redirect_valid_i,
                             bus.redirect_target_i, bus.trap_valid_i);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        cmp("model_pc", bus.pc_o, m.pc);
        cmp("model_pc_plus", bus.pc_plus_o, m.pc + 32'd4);
        cmp("model_valid", {31'd0, bus.pc_valid_o}, {31'd0, (m.mode == M_RUN)});
        cmp("model_misalign", {31'd0, bus.misalign_o}, {31'd0, m.mis});
    endtask

    task automatic idle();
        bus.stall_i = 1'b0;
        bus.if_ready_i = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_target_i = 32'h0;
        bus.trap_valid_i = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        idle();
        repeat (3) tick();
        cmp("reset_pc", bus.pc_o, 32'h0);
        cmp("reset_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        cmp("reset_misalign", {31'd0, bus.misalign_o}, 32'd0);

        // Reset release, boot bubble, sequential run.
        @(posedge clk); #1 rst = 1'b1;
        tick();
        cmp("boot_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        cmp("boot_pc", bus.pc_o, 32'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            cmp("run_pc", bus.pc_o, 32'(4 * k));
            cmp("run_valid", {31'd0, bus.pc_valid_o}, 32'd1);
        end

        // Stall holds, redirect overrides stall.
        bus.redirect_valid_i = 1'b1; bus.redirect_target_i = 32'h10;
        tick();
        cmp("redir_10", bus.pc_o, 32'h10);
        bus.redirect_valid_i = 1'b0; bus.stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            cmp("stall_hold", bus.pc_o, 32'h10);
        end
        bus.redirect_valid_i = 1'b1; bus.redirect_target_i = 32'h1234_5678;
        tick();
        cmp("redir_over_stall", bus.pc_o, 32'h1234_5678);

        // Pending redirect while memory not ready.
        bus.stall_i = 1'b0; bus.if_ready_i = 1'b0;
        bus.redirect_target_i = 32'h9ABC_DEF0;
        tick();
        cmp("pend_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        cmp("pend_pc", bus.pc_o, 32'h1234_5678);
        bus.redirect_valid_i = 1'b0;
        tick();
        cmp("pend_hold", bus.pc_o, 32'h1234_5678);
        bus.if_ready_i = 1'b1;
        tick();
        cmp("pend_apply_pc", bus.pc_o, 32'h9ABC_DEF0);
        cmp("pend_apply_valid", {31'd0, bus.pc_valid_o}, 32'd1);

        // Trap beats redirect; wrap at top of address space.
        bus.trap_valid_i = 1'b1; bus.redirect_valid_i = 1'b1; bus.redirect_target_i = 32'h40;
        tick();
        cmp("trap_prio", bus.pc_o, 32'h100);
        bus.trap_valid_i = 1'b0; bus.redirect_target_i = 32'hFFFF_FFFC;
        tick();
        cmp("top_pc", bus.pc_o, 32'hFFFF_FFFC);
        cmp("top_pc_plus", bus.pc_plus_o, 32'h0);
        bus.redirect_valid_i = 1'b0;
        tick();
        cmp("wrap_pc", bus.pc_o, 32'h0);

        // Misaligned redirect.
        bus.redirect_valid_i = 1'b1; bus.redirect_target_i = 32'h9ABC_DEFF;
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        cmp("misalign_pc", bus.pc_o, 32'h100);
        cmp("misalign_pulse", {31'd0, bus.misalign_o}, 32'd1);
`else
        cmp("misalign_pc", bus.pc_o, 32'h9ABC_DEFC);
        cmp("misalign_pulse", {31'd0, bus.misalign_o}, 32'd0);
`endif
        bus.redirect_valid_i = 1'b0; bus.stall_i = 1'b1;
        tick();
        cmp("misalign_after", {31'd0, bus.misalign_o}, 32'd0);

        // Asynchronous reset while a target is pending.
        bus.stall_i = 1'b0; bus.if_ready_i = 1'b0;
        bus.redirect_valid_i = 1'b1; bus.redirect_target_i = 32'h5555_0000;
        tick();
        cmp("pend2_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        bus.redirect_valid_i = 1'b0;
        #2 rst = 1'b0;
        #1 cmp("async_rst_pc", bus.pc_o, 32'h0);
        cmp("async_rst_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b1; bus.if_ready_i = 1'b1;
        tick();
        cmp("reboot_valid", {31'd0, bus.pc_valid_o}, 32'd0);
        cmp("reboot_pc", bus.pc_o, 32'h0);
        tick();
        cmp("reboot_run_pc", bus.pc_o, 32'h0);
        cmp("reboot_run_valid", {31'd0, bus.pc_valid_o}, 32'd1);
        tick();
        cmp("reboot_next_pc", bus.pc_o, 32'h4);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.stall_i = ($urandom_range(99) < 30);
            bus.if_ready_i = ($urandom_range(99) < 70);
            bus.redirect_valid_i = ($urandom_range(99) < 12);
            bus.trap_valid_i = ($urandom_range(99) < 4);
            if ($urandom_range(1) == 0) bus.redirect_target_i = $urandom() & 32'hFFFF_FFFC;
            else bus.redirect_target_i = $urandom();
            if ($urandom_range(299) == 0) begin
                #2 rst = 1'b0;
                @(posedge clk); #1 rst = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL provide parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL provide parameter STEP, default 4, sequential increment; power of two, at least 1.
REQ-004 SHALL provide parameter TRAP_VECTOR, default 32'h0000_0100, trap redirect address.
REQ-005 SHALL provide clk  input  1  rising-edge clock.
REQ-006 SHALL provide rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 SHALL provide stall_i  input  1  hazard stall; hold PC.
REQ-008 SHALL provide if_ready_i  input  1  instruction memory accepts the current pc_o.
REQ-009 SHALL provide redirect_valid_i  input  1  branch/jump taken from EX.
REQ-010 SHALL provide redirect_target_i  input  XLEN  redirect address.
REQ-011 SHALL provide trap_valid_i  input  1  exception; redirect to TRAP_VECTOR.
REQ-012 SHALL provide pc_o  output  XLEN  current fetch address.
REQ-013 SHALL provide pc_plus_o  output  XLEN  combinational pc_o + STEP, modulo 2^XLEN.
REQ-014 SHALL provide pc_valid_o  output  1  pc_o is a valid fetch request.
REQ-015 SHALL provide misalign_o  output  1  one-cycle pulse on a misaligned redirect.

Function
REQ-016 SHALL implement FSM states BOOT, RUN and PEND, registered on clk.
REQ-017 BOOT SHALL drive pc_valid_o=0 for exactly one cycle after reset release, then go to RUN with pc_o unchanged.
REQ-018 RUN SHALL drive pc_valid_o=1.
- Fire condition: advance = RUN & if_ready_i & ~stall_i.
- On advance, pc_o SHALL take pc_o+STEP on the next edge.
REQ-019 In RUN with ~advance and no redirect or trap, pc_o SHALL hold.
REQ-020 Sequential increment SHALL wrap modulo 2^XLEN (e.g. 32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-021 Event priority SHALL be trap_valid_i > redirect_valid_i > stall_i > advance.
- Redirect and trap SHALL override stall_i.
REQ-022 Trap or redirect with if_ready_i=1 in RUN SHALL load the new target into pc_o on the next edge and stay in RUN (latency 1 cycle).
REQ-023 Trap or redirect with if_ready_i=0 in RUN SHALL:
- latch the target into a pending register,
- go to PEND with pc_valid_o=0,
- leave pc_o unchanged.
REQ-024 PEND SHALL load the pending target into pc_o and return to RUN on the first cycle with if_ready_i=1.
REQ-025 A new trap or redirect arriving in PEND SHALL overwrite the pending target using the REQ-021 priority; last event wins.
REQ-026 A redirect in BOOT SHALL load pc_o and go to RUN (no extra bubble).
REQ-027 A target is misaligned when any bit below log2(STEP) is set; handling is per REQ-031/REQ-032.
REQ-028 pc_plus_o SHALL always equal pc_o+STEP truncated to XLEN, including in BOOT and PEND.

Reset
REQ-029 While rst=0, regardless of clk, the block SHALL force:
- pc_o=RESET_VECTOR
- pc_valid_o=0
- misalign_o=0
- state=BOOT
- pending register=0
REQ-030 Reset asserted mid-operation (including in PEND) SHALL discard any pending target; after release, REQ-017 applies.

Configuration
REQ-031 With PC_MISALIGN_TRAP_EN defined, a misaligned redirect SHALL:
- be replaced by TRAP_VECTOR,
- pulse misalign_o=1 for the cycle in which pc_o loads TRAP_VECTOR.
REQ-032 With PC_MISALIGN_TRAP_EN undefined, a misaligned redirect target SHALL have its low log2(STEP) bits cleared, and misalign_o SHALL be tied 0.

Verification
REQ-033 Reset then run: rst=0 then 1, if_ready_i=1, stall_i=0 -> one cycle pc_valid_o=0, then pc_o=0,4,8,...,36 on successive cycles.
REQ-034 Stall priority:
- stall_i=1 for 3 cycles at pc_o=32'h10 -> pc_o holds 32'h10.
- redirect 32'h1234_5678 during the stall -> pc_o=32'h1234_5678 next cycle.
REQ-035 Pending redirect: if_ready_i=0, redirect 32'h9ABC_DEF0 -> PEND, pc_valid_o=0, pc_o unchanged; if_ready_i=1 -> pc_o=32'h9ABC_DEF0, pc_valid_o=1.
REQ-036 Priority and wrap:
- trap_valid_i and redirect 32'h40 in the same cycle -> pc_o=32'h100.
- pc_o=32'hFFFF_FFFC, advance -> pc_o=32'h0.
REQ-037 Misaligned redirect to 32'h9ABC_DEFF:
- with the macro -> pc_o=32'h100, misalign_o pulses once.
- without the macro -> pc_o=32'h9ABC_DEFC, misalign_o=0.
REQ-038 Reset in PEND: assert rst=0 asynchronously between edges -> pc_o=0 immediately; after release, BOOT runs and the pending target is not applied.
